// File: rtl/stack_pkg.sv
// Shared definitions for the 8080 stack sequencer.
//   stack_op_t : request opcode encoding (values 4-7 are illegal)
//   state_t    : sequencer state encoding
//   *_DEF      : default parameter values for stack_seq
package stack_pkg;

  typedef enum logic [2:0] {
    OP_PUSH    = 3'd0,
    OP_POP     = 3'd1,
    OP_XTHL    = 3'd2,
    OP_LOAD_SP = 3'd3
  } stack_op_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_RD_WAIT,
    S_WR_HI,
    S_WR_LO,
    S_XW_LO,
    S_XW_HI,
    S_DONE
  } state_t;

  localparam int          READ_LAT_DEF    = 2;
  localparam logic [15:0] SP_RESET_DEF    = 16'h0000;
  localparam logic [15:0] STACK_LIMIT_DEF = 16'hC000;

  // A PUSH moves SP down by two; it is refused if that lands below the floor.
  function automatic logic push_overflows(input logic [15:0] sp_cur,
                                          input logic [15:0] limit);
    logic [15:0] sp_new;
    sp_new = sp_cur - 16'd2;
    return sp_new < limit;
  endfunction

endpackage

// File: rtl/stack_seq.sv
// stack_seq: executes PUSH / POP / XTHL / LOAD_SP as byte-wide memory
// sequences on behalf of the 8080 execute stage and owns the stack pointer.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_op, req_data           opcode and word / new SP
//   resp_valid, resp_data      one-cycle completion pulse and result
//   resp_err                   overflow or illegal opcode
//   sp                         current stack pointer
//   mem_raddr, mem_rdata       byte read port (data READ_LAT cycles later)
//   mem_wen, mem_waddr/wdata   byte write port
//
// All outputs except req_ready are registered: each cycle's outputs are
// computed from the state being entered.
module stack_seq
  import stack_pkg::*;
#(
  parameter int          READ_LAT    = READ_LAT_DEF,
  parameter logic [15:0] SP_RESET    = SP_RESET_DEF,
  parameter logic [15:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_data,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_err,
  output logic [15:0] sp,
  output logic [15:0] mem_raddr,
  input  logic [7:0]  mem_rdata,
  output logic        mem_wen,
  output logic [15:0] mem_waddr,
  output logic [7:0]  mem_wdata
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [15:0]         wdat_q, wdat_d;     // word latched at acceptance
  logic [15:0]         word_q, word_d;     // word assembled from reads
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [READ_LAT-1:0] lo_pipe_q, lo_pipe_d;
  logic [READ_LAT-1:0] hi_pipe_q, hi_pipe_d;
  logic                lo_issue, hi_issue;

  logic [15:0] sp_q, sp_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [15:0] resp_data_q, resp_data_d;
  logic [15:0] mem_raddr_q, mem_raddr_d;
  logic        mem_wen_q, mem_wen_d;
  logic [15:0] mem_waddr_q, mem_waddr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;

  logic [15:0] sp_m1, sp_m2, sp_p1, sp_p2;

  assign sp_m1 = sp_q - 16'd1;
  assign sp_m2 = sp_q - 16'd2;
  assign sp_p1 = sp_q + 16'd1;
  assign sp_p2 = sp_q + 16'd2;

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;
  assign sp         = sp_q;
  assign mem_raddr  = mem_raddr_q;
  assign mem_wen    = mem_wen_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_wdata  = mem_wdata_q;

  // Read-return tagging: a tag enters the pipe in the cycle its address is on
  // mem_raddr and reaches the top bit in the cycle its data is on mem_rdata.
  always_comb begin
    lo_pipe_d    = lo_pipe_q << 1;
    lo_pipe_d[0] = lo_issue;
    hi_pipe_d    = hi_pipe_q << 1;
    hi_pipe_d[0] = hi_issue;
    word_d       = word_q;
    if (lo_pipe_q[READ_LAT-1]) word_d[7:0]  = mem_rdata;
    if (hi_pipe_q[READ_LAT-1]) word_d[15:8] = mem_rdata;
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wdat_d       = wdat_q;
    cnt_d        = cnt_q;
    sp_d         = sp_q;
    lo_issue     = 1'b0;
    hi_issue     = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_data_d  = resp_data_q;
    mem_raddr_d  = mem_raddr_q;
    mem_wen_d    = 1'b0;
    mem_waddr_d  = mem_waddr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          wdat_d = req_data;
          case (req_op)
            OP_PUSH: begin
              if (push_overflows(sp_q, STACK_LIMIT)) begin
                state_d      = S_DONE;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                resp_data_d  = sp_q;
              end else begin
                state_d     = S_WR_HI;
                mem_wen_d   = 1'b1;
                mem_waddr_d = sp_m1;
                mem_wdata_d = req_data[15:8];
              end
            end
            OP_POP, OP_XTHL: begin
              state_d     = S_RD_LO;
              mem_raddr_d = sp_q;
            end
            OP_LOAD_SP: begin
              state_d      = S_DONE;
              sp_d         = req_data;
              resp_valid_d = 1'b1;
              resp_data_d  = req_data;
            end
            default: begin
              state_d      = S_DONE;
              resp_valid_d = 1'b1;
              resp_err_d   = 1'b1;
              resp_data_d  = sp_q;
            end
          endcase
        end
      end
      S_RD_LO: begin
        lo_issue    = 1'b1;
        state_d     = S_RD_HI;
        mem_raddr_d = sp_p1;
      end
      S_RD_HI: begin
        hi_issue = 1'b1;
        state_d  = S_RD_WAIT;
        cnt_d    = CNT_W'(READ_LAT - 1);
      end
      S_RD_WAIT: begin
        // Last wait cycle is the one the high byte is on mem_rdata.
        if (cnt_q == '0) begin
          if (op_q == OP_XTHL) begin
            state_d     = S_XW_LO;
            mem_wen_d   = 1'b1;
            mem_waddr_d = sp_q;
            mem_wdata_d = wdat_q[7:0];
          end else begin
            state_d      = S_DONE;
            sp_d         = sp_p2;
            resp_valid_d = 1'b1;
            resp_data_d  = word_d;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WR_HI: begin
        state_d     = S_WR_LO;
        mem_wen_d   = 1'b1;
        mem_waddr_d = sp_m2;
        mem_wdata_d = wdat_q[7:0];
      end
      S_WR_LO: begin
        state_d      = S_DONE;
        sp_d         = sp_m2;
        resp_valid_d = 1'b1;
        resp_data_d  = sp_m2;
      end
      S_XW_LO: begin
        state_d     = S_XW_HI;
        mem_wen_d   = 1'b1;
        mem_waddr_d = sp_p1;
        mem_wdata_d = wdat_q[15:8];
      end
      S_XW_HI: begin
        state_d      = S_DONE;
        resp_valid_d = 1'b1;
        resp_data_d  = word_q;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      wdat_q       <= '0;
      word_q       <= '0;
      cnt_q        <= '0;
      lo_pipe_q    <= '0;
      hi_pipe_q    <= '0;
      sp_q         <= SP_RESET;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      mem_raddr_q  <= '0;
      mem_wen_q    <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wdat_q       <= wdat_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      lo_pipe_q    <= lo_pipe_d;
      hi_pipe_q    <= hi_pipe_d;
      sp_q         <= sp_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      mem_raddr_q  <= mem_raddr_d;
      mem_wen_q    <= mem_wen_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: directed requests, a byte memory with 2-cycle read
// latency, and a per-cycle expectation table filled from the op rules.
module tb_stack_seq;

  localparam int          RL  = 2;
  localparam logic [15:0] SPR = 16'h0000;
  localparam logic [15:0] LIM = 16'hC000;
  localparam int          N   = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [15:0] req_data = '0;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_err;
  logic [15:0] sp;
  logic [15:0] mem_raddr;
  logic [7:0]  mem_rdata;
  logic        mem_wen;
  logic [15:0] mem_waddr;
  logic [7:0]  mem_wdata;

  always #5 clk = ~clk;

  stack_seq #(.READ_LAT(RL), .SP_RESET(SPR), .STACK_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err), .sp(sp),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  // Main memory: address registered, then data registered (2-cycle latency).
  logic [7:0]  mem [0:65535];
  logic [15:0] ra_q;
  logic [7:0]  rd_q;
  always @(posedge clk) begin
    ra_q <= mem_raddr;
    rd_q <= mem[ra_q];
    if (mem_wen) mem[mem_waddr] <= mem_wdata;
  end
  assign mem_rdata = rd_q;

  // Expected behaviour per cycle.
  bit          e_busy [N];
  bit          e_wen  [N];
  logic [15:0] e_waddr[N];
  logic [7:0]  e_wdata[N];
  bit          e_rd   [N];
  logic [15:0] e_raddr[N];
  bit          e_rv   [N];
  logic [15:0] e_rdata[N];
  bit          e_err  [N];
  logic [15:0] e_sp   [N];

  logic [7:0]  m_mem [0:65535];
  logic [15:0] m_sp;

  int cyc, n_chk, n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
  endtask

  task automatic compare();
    if (cyc < N) begin
      chk("req_ready", 32'(req_ready), 32'(!e_busy[cyc]));
      chk("mem_wen", 32'(mem_wen), 32'(e_wen[cyc]));
      if (e_wen[cyc]) begin
        chk("mem_waddr", 32'(mem_waddr), 32'(e_waddr[cyc]));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata[cyc]));
      end
      if (e_rd[cyc]) chk("mem_raddr", 32'(mem_raddr), 32'(e_raddr[cyc]));
      chk("resp_valid", 32'(resp_valid), 32'(e_rv[cyc]));
      if (e_rv[cyc]) begin
        chk("resp_data", 32'(resp_data), 32'(e_rdata[cyc]));
        chk("resp_err", 32'(resp_err), 32'(e_err[cyc]));
      end
      chk("sp", 32'(sp), 32'(e_sp[cyc]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compare();
  endtask

  task automatic set_sp_from(input int c, input logic [15:0] v);
    for (int i = c; i < N; i++) e_sp[i] = v;
  endtask

  task automatic post_wr(input int c, input logic [15:0] a, input logic [7:0] d);
    e_wen[c] = 1'b1; e_waddr[c] = a; e_wdata[c] = d;
    m_mem[a] = d;
  endtask

  task automatic post_rd(input int c, input logic [15:0] a);
    e_rd[c] = 1'b1; e_raddr[c] = a;
  endtask

  task automatic post_resp(input int c0, input int c, input logic [15:0] d, input bit err);
    for (int i = c0 + 1; i <= c; i++) e_busy[i] = 1'b1;
    e_rv[c] = 1'b1; e_rdata[c] = d; e_err[c] = err;
  endtask

  // Presents a request (held until accepted) and records what must follow.
  // Returns in cycle c0+1.
  task automatic issue(input logic [2:0] op, input logic [15:0] d, output int c0);
    logic [15:0] s, n, w;
    int k;
    req_valid = 1'b1; req_op = op; req_data = d;
    k = 0;
    while (!req_ready && k < 64) begin tick(); k++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0; c0 = -1;
      return;
    end
    c0 = cyc;
    s  = m_sp;
    case (op)
      3'd0: begin
        n = s - 16'd2;
        if (n < LIM) post_resp(c0, c0 + 1, s, 1'b1);
        else begin
          post_wr(c0 + 1, s - 16'd1, d[15:8]);
          post_wr(c0 + 2, n, d[7:0]);
          post_resp(c0, c0 + 3, n, 1'b0);
          set_sp_from(c0 + 3, n);
          m_sp = n;
        end
      end
      3'd1, 3'd2: begin
        post_rd(c0 + 1, s);
        post_rd(c0 + 2, s + 16'd1);
        w = {m_mem[s + 16'd1], m_mem[s]};
        if (op == 3'd1) begin
          post_resp(c0, c0 + 3 + RL, w, 1'b0);
          set_sp_from(c0 + 3 + RL, s + 16'd2);
          m_sp = s + 16'd2;
        end else begin
          post_wr(c0 + 3 + RL, s, d[7:0]);
          post_wr(c0 + 4 + RL, s + 16'd1, d[15:8]);
          post_resp(c0, c0 + 5 + RL, w, 1'b0);
        end
      end
      3'd3: begin
        post_resp(c0, c0 + 1, d, 1'b0);
        set_sp_from(c0 + 1, d);
        m_sp = d;
      end
      default: post_resp(c0, c0 + 1, s, 1'b1);
    endcase
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!req_ready && k < 64) begin tick(); k++; end
    if (!req_ready) chk("idle_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic run(input logic [2:0] op, input logic [15:0] d);
    int c0;
    issue(op, d, c0);
    wait_idle();
  endtask

  initial begin
    int c0, c1;
    for (int i = 0; i < N; i++) begin
      e_busy[i] = 0; e_wen[i] = 0; e_rd[i] = 0; e_rv[i] = 0; e_err[i] = 0;
      e_waddr[i] = '0; e_wdata[i] = '0; e_raddr[i] = '0; e_rdata[i] = '0;
      e_sp[i] = SPR;
    end
    m_sp = SPR; cyc = 0; n_chk = 0; n_pass = 0;

    // Reset state.
    #2;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_mem_raddr", 32'(mem_raddr), 32'd0);
    chk("rst_mem_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_sp", 32'(sp), 32'(SPR));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // First PUSH from SP=0000 wraps to FFFF/FFFE.
    issue(3'd0, 16'h1234, c0);
    chk("push_c1_waddr", 32'(mem_waddr), 32'h0000FFFF);
    chk("push_c1_wdata", 32'(mem_wdata), 32'h12);
    tick();
    chk("push_c2_waddr", 32'(mem_waddr), 32'h0000FFFE);
    chk("push_c2_wdata", 32'(mem_wdata), 32'h34);
    tick();
    chk("push_c3_rv", 32'(resp_valid), 32'd1);
    chk("push_c3_data", 32'(resp_data), 32'h0000FFFE);
    chk("push_c3_sp", 32'(sp), 32'h0000FFFE);
    wait_idle();

    // POP back; SP wraps to 0000.
    issue(3'd1, 16'h0000, c0);
    tick(); tick(); tick(); tick();
    chk("pop_c5_rv", 32'(resp_valid), 32'd1);
    chk("pop_c5_data", 32'(resp_data), 32'h00001234);
    chk("pop_c5_sp", 32'(sp), 32'h00000000);
    wait_idle();

    // Build FFFC=78, FFFD=56 then XTHL ABCD.
    run(3'd3, 16'hFFFE);
    run(3'd0, 16'h5678);
    issue(3'd2, 16'hABCD, c0);
    for (int i = 0; i < 6; i++) tick();
    chk("xthl_c7_rv", 32'(resp_valid), 32'd1);
    chk("xthl_c7_data", 32'(resp_data), 32'h00005678);
    chk("xthl_c7_sp", 32'(sp), 32'h0000FFFC);
    wait_idle();
    chk("xthl_mem_lo", 32'(mem[16'hFFFC]), 32'hCD);
    chk("xthl_mem_hi", 32'(mem[16'hFFFD]), 32'hAB);
    issue(3'd1, 16'h0000, c0);
    tick(); tick(); tick(); tick();
    chk("pop_after_xthl", 32'(resp_data), 32'h0000ABCD);
    wait_idle();

    // Stack floor.
    run(3'd3, 16'hC001);
    issue(3'd0, 16'h1111, c0);
    chk("ovf_rv", 32'(resp_valid), 32'd1);
    chk("ovf_err", 32'(resp_err), 32'd1);
    chk("ovf_data", 32'(resp_data), 32'h0000C001);
    chk("ovf_wen", 32'(mem_wen), 32'd0);
    wait_idle();
    run(3'd3, 16'hC002);
    issue(3'd0, 16'h2222, c0);
    tick(); tick();
    chk("floor_ok_err", 32'(resp_err), 32'd0);
    chk("floor_ok_sp", 32'(sp), 32'h0000C000);
    wait_idle();
    run(3'd0, 16'h3333);

    // Illegal ops.
    issue(3'd5, 16'h5555, c0);
    chk("ill_err", 32'(resp_err), 32'd1);
    chk("ill_data", 32'(resp_data), 32'h0000C000);
    wait_idle();
    run(3'd7, 16'h7777);

    // LOAD_SP held during a POP waits for req_ready.
    issue(3'd1, 16'h0000, c0);
    issue(3'd3, 16'hD000, c1);
    chk("held_accept_cyc", 32'(c1), 32'(c0 + 3 + RL + 1));
    chk("held_sp", 32'(sp), 32'h0000D000);
    wait_idle();

    // Reset during PUSH cycle c1.
    issue(3'd0, 16'h9999, c0);
    chk("rstmid_c1_wen", 32'(mem_wen), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_wen", 32'(mem_wen), 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    chk("rstmid_sp", 32'(sp), 32'(SPR));
    for (int i = cyc + 1; i < N; i++) begin
      e_busy[i] = 0; e_wen[i] = 0; e_rd[i] = 0; e_rv[i] = 0;
    end
    set_sp_from(cyc + 1, SPR);
    m_sp = SPR;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run(3'd0, 16'h4321);
    chk("post_rst_mem", 32'(mem[16'hFFFE]), 32'h21);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
